// File: rtl/double_buffer_load_ctrl.sv
// Load sequencer for a two-bank buffer: fills the inactive bank from a valid/ready
// stream, then issues a one-cycle swap once the consumer has released the active bank.
module double_buffer_load_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 3,
  localparam int AW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  abort,
  input  logic                  consume_done,
  output logic [AW-1:0]         load_addr,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_we,
  output logic                  swap_buffers,
  output logic                  active_valid,
  output logic [15:0]           frames_swapped
);

  typedef enum logic {FILL, FULL} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(MATRIX_SIZE - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         load_addr_q, load_addr_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  load_we_q, load_we_d;
  logic                  swap_q, swap_d;
  logic                  active_q, active_d;
  logic [15:0]           frames_q, frames_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      load_addr_q <= '0;
      load_data_q <= '0;
      load_we_q   <= 1'b0;
      swap_q      <= 1'b0;
      active_q    <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
      load_we_q   <= load_we_d;
      swap_q      <= swap_d;
      active_q    <= active_d;
      frames_q    <= frames_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;
    load_we_d   = 1'b0;
    swap_d      = 1'b0;
    active_d    = active_q;
    frames_d    = frames_q;
    case (state_q)
      FILL: begin
        if (consume_done) active_d = 1'b0;
        // abort drops the element offered in the same cycle
        if (abort) begin
          idx_d = '0;
        end else if (in_valid) begin
          load_we_d   = 1'b1;
          load_addr_d = idx_q;
          load_data_d = in_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (abort) begin
          state_d = FILL;
          if (consume_done) active_d = 1'b0;
        end else if (!active_q || consume_done) begin
          // a coincident consume_done is absorbed: the new frame becomes active
          swap_d   = 1'b1;
          active_d = 1'b1;
          frames_d = frames_q + 16'd1;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready       = (state_q == FILL) && !rst;
  assign load_addr      = load_addr_q;
  assign load_data      = load_data_q;
  assign load_we        = load_we_q;
  assign swap_buffers   = swap_q;
  assign active_valid   = active_q;
  assign frames_swapped = frames_q;

endmodule

// File: tb/tb_double_buffer_load_ctrl.sv
// Directed bench for double_buffer_load_ctrl driving a behavioural two-bank buffer.
module tb_double_buffer_load_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        abort;
  logic        consume_done;
  logic [1:0]  load_addr;
  logic [7:0]  load_data;
  logic        load_we;
  logic        swap_buffers;
  logic        active_valid;
  logic [15:0] frames_swapped;

  int checks = 0;
  int errors = 0;

  double_buffer_load_ctrl #(.DATA_WIDTH(8), .MATRIX_SIZE(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .consume_done(consume_done), .load_addr(load_addr), .load_data(load_data),
    .load_we(load_we), .swap_buffers(swap_buffers), .active_valid(active_valid),
    .frames_swapped(frames_swapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached buffer: writes go to the inactive bank, out shows the active bank.
  logic [7:0]  b0 [3];
  logic [7:0]  b1 [3];
  logic        sel;
  logic [23:0] buf_out;

  always @(posedge clk) begin
    if (rst) begin
      sel <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        b0[i] <= 8'd0;
        b1[i] <= 8'd0;
      end
    end else begin
      if (load_we && load_addr < 2'd3) begin
        if (sel) b0[int'(load_addr)] <= load_data;
        else     b1[int'(load_addr)] <= load_data;
      end
      if (swap_buffers) sel <= ~sel;
    end
  end

  assign buf_out = sel ? {b1[0], b1[1], b1[2]} : {b0[0], b0[1], b0[2]};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({load_we, swap_buffers, active_valid, in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got we/swap/av/rdy=%b expected 0000",
               {load_we, swap_buffers, active_valid, in_ready});
    end
    checks++;
    if ({load_addr, load_data, frames_swapped} !== 26'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d data=%0d frames=%0d expected all 0",
               load_addr, load_data, frames_swapped);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_stream();
    in_valid = 1'b1;
    in_data  = 8'd10;
    cyc();
    checks++;
    if ({load_we, load_addr, load_data} !== {1'b1, 2'd0, 8'd10}) begin
      errors++;
      $display("FAIL stream_w0: got we=%b addr=%0d data=%0d expected 1/0/10", load_we, load_addr, load_data);
    end
    in_data = 8'd20;
    cyc();
    checks++;
    if ({load_we, load_addr, load_data} !== {1'b1, 2'd1, 8'd20}) begin
      errors++;
      $display("FAIL stream_w1: got we=%b addr=%0d data=%0d expected 1/1/20", load_we, load_addr, load_data);
    end
    in_data = 8'd30;
    cyc();
    checks++;
    if ({load_we, load_addr, load_data, in_ready, swap_buffers} !== {1'b1, 2'd2, 8'd30, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stream_w2: got we=%b addr=%0d data=%0d rdy=%b swap=%b expected 1/2/30/0/0",
               load_we, load_addr, load_data, in_ready, swap_buffers);
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if ({swap_buffers, load_we, active_valid, frames_swapped} !== {1'b1, 1'b0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL stream_swap: got swap=%b we=%b av=%b frames=%0d expected 1/0/1/1",
               swap_buffers, load_we, active_valid, frames_swapped);
    end
    cyc();
    checks++;
    if ({swap_buffers, buf_out} !== {1'b0, 8'd10, 8'd20, 8'd30}) begin
      errors++;
      $display("FAIL stream_buf: got swap=%b out=%h expected 0/0a141e", swap_buffers, buf_out);
    end
  endtask

  task automatic test_stall();
    in_valid = 1'b1;
    in_data  = 8'd40;
    cyc();
    in_data = 8'd50;
    cyc();
    in_data = 8'd60;
    cyc();
    checks++;
    if ({load_addr, load_data, in_ready} !== {2'd2, 8'd60, 1'b0}) begin
      errors++;
      $display("FAIL stall_last: got addr=%0d data=%0d rdy=%b expected 2/60/0", load_addr, load_data, in_ready);
    end
    in_data = 8'd99;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({swap_buffers, load_we, in_ready} !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold%0d: got swap/we/rdy=%b expected 000", i, {swap_buffers, load_we, in_ready});
      end
    end
    consume_done = 1'b1;
    in_valid     = 1'b0;
    cyc();
    consume_done = 1'b0;
    checks++;
    if ({swap_buffers, active_valid, frames_swapped} !== {1'b1, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL stall_swap: got swap=%b av=%b frames=%0d expected 1/1/2",
               swap_buffers, active_valid, frames_swapped);
    end
    cyc();
    checks++;
    if ({swap_buffers, active_valid, buf_out} !== {1'b0, 1'b1, 8'd40, 8'd50, 8'd60}) begin
      errors++;
      $display("FAIL stall_buf: got swap=%b av=%b out=%h expected 0/1/28323c", swap_buffers, active_valid, buf_out);
    end
  endtask

  task automatic test_consume_fill();
    consume_done = 1'b1;
    cyc();
    consume_done = 1'b0;
    checks++;
    if ({active_valid, swap_buffers} !== 2'b00) begin
      errors++;
      $display("FAIL cfill_clear: got av/swap=%b expected 00", {active_valid, swap_buffers});
    end
    in_valid = 1'b1;
    in_data  = 8'd5;
    cyc();
    in_data = 8'd6;
    cyc();
    in_data = 8'd7;
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++;
    if ({swap_buffers, active_valid, frames_swapped} !== {1'b1, 1'b1, 16'd3}) begin
      errors++;
      $display("FAIL cfill_swap: got swap=%b av=%b frames=%0d expected 1/1/3",
               swap_buffers, active_valid, frames_swapped);
    end
    cyc();
    checks++;
    if (buf_out !== {8'd5, 8'd6, 8'd7}) begin
      errors++;
      $display("FAIL cfill_buf: got %h expected 050607", buf_out);
    end
    consume_done = 1'b1;
    cyc();
    cyc();
    consume_done = 1'b0;
    checks++;
    if ({active_valid, swap_buffers, frames_swapped} !== {1'b0, 1'b0, 16'd3}) begin
      errors++;
      $display("FAIL cfill_idle: got av=%b swap=%b frames=%0d expected 0/0/3",
               active_valid, swap_buffers, frames_swapped);
    end
  endtask

  task automatic test_abort();
    in_valid = 1'b1;
    in_data  = 8'd70;
    cyc();
    in_data = 8'd80;
    cyc();
    abort   = 1'b1;
    in_data = 8'd90;
    cyc();
    abort = 1'b0;
    checks++;
    if ({load_we, in_ready, swap_buffers} !== 3'b010) begin
      errors++;
      $display("FAIL abort_fill: got we/rdy/swap=%b expected 010", {load_we, in_ready, swap_buffers});
    end
    in_data = 8'd1;
    cyc();
    checks++;
    if ({load_we, load_addr, load_data} !== {1'b1, 2'd0, 8'd1}) begin
      errors++;
      $display("FAIL abort_restart: got we=%b addr=%0d data=%0d expected 1/0/1", load_we, load_addr, load_data);
    end
    in_data = 8'd2;
    cyc();
    in_data = 8'd3;
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++;
    if ({swap_buffers, frames_swapped} !== {1'b1, 16'd4}) begin
      errors++;
      $display("FAIL abort_swap: got swap=%b frames=%0d expected 1/4", swap_buffers, frames_swapped);
    end
    cyc();
    checks++;
    if (buf_out !== {8'd1, 8'd2, 8'd3}) begin
      errors++;
      $display("FAIL abort_buf: got %h expected 010203", buf_out);
    end
    consume_done = 1'b1;
    cyc();
    consume_done = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd11;
    cyc();
    in_data = 8'd12;
    cyc();
    in_data = 8'd13;
    cyc();
    in_valid = 1'b0;
    abort    = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if ({swap_buffers, in_ready, active_valid, frames_swapped} !== {1'b0, 1'b1, 1'b0, 16'd4}) begin
      errors++;
      $display("FAIL abort_full: got swap=%b rdy=%b av=%b frames=%0d expected 0/1/0/4",
               swap_buffers, in_ready, active_valid, frames_swapped);
    end
    cyc();
    checks++;
    if ({swap_buffers, buf_out} !== {1'b0, 8'd1, 8'd2, 8'd3}) begin
      errors++;
      $display("FAIL abort_full_buf: got swap=%b out=%h expected 0/010203", swap_buffers, buf_out);
    end
  endtask

  task automatic test_rst_mid();
    in_valid = 1'b1;
    in_data  = 8'd21;
    cyc();
    in_data = 8'd22;
    cyc();
    in_data = 8'd23;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({active_valid, frames_swapped, buf_out} !== {1'b1, 16'd5, 8'd21, 8'd22, 8'd23}) begin
      errors++;
      $display("FAIL rmid_pre: got av=%b frames=%0d out=%h expected 1/5/151617",
               active_valid, frames_swapped, buf_out);
    end
    in_valid = 1'b1;
    in_data  = 8'd31;
    cyc();
    rst     = 1'b1;
    in_data = 8'd32;
    cyc();
    checks++;
    if ({load_we, swap_buffers, active_valid, in_ready, load_addr, frames_swapped} !== 22'd0) begin
      errors++;
      $display("FAIL rmid_reset: got we=%b swap=%b av=%b rdy=%b addr=%0d frames=%0d expected all 0",
               load_we, swap_buffers, active_valid, in_ready, load_addr, frames_swapped);
    end
    rst     = 1'b0;
    in_data = 8'd41;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ready: got %b expected 1", in_ready);
    end
    cyc();
    checks++;
    if ({load_we, load_addr, load_data} !== {1'b1, 2'd0, 8'd41}) begin
      errors++;
      $display("FAIL rmid_w0: got we=%b addr=%0d data=%0d expected 1/0/41", load_we, load_addr, load_data);
    end
    in_data = 8'd42;
    cyc();
    in_data = 8'd43;
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++;
    if ({swap_buffers, active_valid, frames_swapped} !== {1'b1, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL rmid_swap: got swap=%b av=%b frames=%0d expected 1/1/1",
               swap_buffers, active_valid, frames_swapped);
    end
    cyc();
    checks++;
    if (buf_out !== {8'd41, 8'd42, 8'd43}) begin
      errors++;
      $display("FAIL rmid_buf: got %h expected 292a2b", buf_out);
    end
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = 8'd0;
    abort        = 1'b0;
    consume_done = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_consume_fill();
    test_abort();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
